// File: rtl/ccip_rd_arb_pkg.sv
// Shared constants for the CCI-P C0 read arbiter: mdata field layout and
// the round-robin pointer helper.
package ccip_rd_arb_pkg;

    localparam int MDATA_W = 16;
    localparam int ID_MSB  = 15;
    localparam int ID_LSB  = 12;
    localparam int ID_W    = ID_MSB - ID_LSB + 1;
    localparam int RR_W    = ID_W - 1;

    // Next round-robin start position after granting idx, wrapping at num_req.
    function automatic logic [RR_W-1:0] rr_next(
        input logic [RR_W-1:0] idx,
        input logic [ID_W-1:0] num_req
    );
        logic [ID_W-1:0] nxt;
        nxt = {1'b0, idx} + ID_W'(1);
        return (nxt >= num_req) ? {RR_W{1'b0}} : nxt[RR_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the
// pointer (wrapping); the pointer moves past each winner.
module rr_arbiter
    import ccip_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [RR_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [RR_W-1:0] rr_ptr;

    // Two passes: indices at/after the pointer first, then wrap to the lowest request.
    always_comb begin : pick
        logic            found;
        logic [RR_W-1:0] idx;
        found = 1'b0;
        idx   = {RR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (!found && req[i] && (RR_W'(i) >= rr_ptr)) ? RR_W'(i) : idx;
            found = found | (req[i] && (RR_W'(i) >= rr_ptr));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (!found && req[i]) ? RR_W'(i) : idx;
            found = found | req[i];
        end
        grant_valid = found;
        grant_idx   = idx;
        grant       = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (idx == RR_W'(i));
        end
    end

    // Pointer register, advanced only when something is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= {RR_W{1'b0}};
        end else if (grant_valid) begin
            rr_ptr <= rr_next(grant_idx, ID_W'(NUM_REQ));
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// Shares the CCI-P Tx C0 read channel among NUM_REQ requesters with per-requester
// credits and routes Rx C0 responses by mdata ID. Optional CCI_RD_ARB_PERF_EN adds perf counters.
module ccip_c0_rd_arbiter
    import ccip_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 42,
    parameter int TAG_W   = 12,
    parameter int MAX_OUT = 64
) (
    input  logic                      clk_400_clk,
    input  logic                      global_reset_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic                      tx_c0_valid,
    output logic [ADDR_W-1:0]         tx_c0_addr,
    output logic [MDATA_W-1:0]        tx_c0_mdata,
    input  logic                      tx_c0_almostfull,
    input  logic                      rx_c0_rdvalid,
    input  logic [MDATA_W-1:0]        rx_c0_mdata,
    input  logic [511:0]              rx_c0_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [511:0]              rsp_data,
    output logic                      err_bad_id
`ifdef CCI_RD_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]     perf_issue_cnt,
    output logic [NUM_REQ*32-1:0]     perf_stall_cnt
`endif
);

    localparam int               CNT_W   = $clog2(MAX_OUT) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  NUM_ID  = ID_W'(NUM_REQ);

    logic                 clk;
    logic                 rst_n;
    logic [CNT_W-1:0]     out_cnt [NUM_REQ];
    logic                 issue_en;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [RR_W-1:0]      grant_idx;
    logic                 grant_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [TAG_W-1:0]     sel_tag;
    logic [MDATA_W-1:0]   issue_mdata;
    logic [ID_W-1:0]      rsp_id;
    logic                 id_ok;
    logic [NUM_REQ-1:0]   rsp_hit;
    logic                 zero_hit;

    assign clk       = clk_400_clk;
    assign rst_n     = global_reset_reset_n;
    // Gating with reset keeps req_ready low while reset is held.
    assign issue_en  = rst_n && !tx_c0_almostfull;
    assign req_ready = grant;
    assign rsp_id    = rx_c0_mdata[ID_MSB:ID_LSB];
    assign id_ok     = rsp_id < NUM_ID;

    // Eligibility, winner's address/tag mux, and response ID decode.
    always_comb begin
        eligible    = {NUM_REQ{1'b0}};
        sel_addr    = {ADDR_W{1'b0}};
        sel_tag     = {TAG_W{1'b0}};
        rsp_hit     = {NUM_REQ{1'b0}};
        zero_hit    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = issue_en && req_valid[i] && (out_cnt[i] < MAX_CNT);
            sel_addr    = sel_addr | ({ADDR_W{grant[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            sel_tag     = sel_tag | ({TAG_W{grant[i]}} & req_tag[i*TAG_W +: TAG_W]);
            rsp_hit[i]  = rx_c0_rdvalid && id_ok && (rsp_id == ID_W'(i));
            zero_hit    = zero_hit | (rsp_hit[i] && (out_cnt[i] == {CNT_W{1'b0}}));
        end
        issue_mdata                = {MDATA_W{1'b0}};
        issue_mdata[ID_MSB:ID_LSB] = {1'b0, grant_idx};
        issue_mdata[TAG_W-1:0]     = sel_tag;
    end

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (eligible),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Issue stage register toward CCI Tx C0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_c0_valid <= 1'b0;
            tx_c0_addr  <= {ADDR_W{1'b0}};
            tx_c0_mdata <= {MDATA_W{1'b0}};
        end else begin
            tx_c0_valid <= grant_valid;
            if (grant_valid) begin
                tx_c0_addr  <= sel_addr;
                tx_c0_mdata <= issue_mdata;
            end
        end
    end

    // Response routing register and sticky bad-ID/underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= {NUM_REQ{1'b0}};
            rsp_tag    <= {TAG_W{1'b0}};
            rsp_data   <= {512{1'b0}};
            err_bad_id <= 1'b0;
        end else begin
            rsp_valid <= rsp_hit;
            if (rx_c0_rdvalid) begin
                rsp_tag  <= rx_c0_mdata[TAG_W-1:0];
                rsp_data <= rx_c0_data;
            end
            if (rx_c0_rdvalid && (!id_ok || zero_hit)) begin
                err_bad_id <= 1'b1;
            end
        end
    end

    // Outstanding-read credits; a grant and a response together cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                out_cnt[i] <= {CNT_W{1'b0}};
            end else begin
                case ({grant[i], rsp_hit[i]})
                    2'b10:   out_cnt[i] <= out_cnt[i] + CNT_W'(1);
                    2'b01:   out_cnt[i] <= (out_cnt[i] != {CNT_W{1'b0}}) ? out_cnt[i] - CNT_W'(1) : out_cnt[i];
                    default: out_cnt[i] <= out_cnt[i];
                endcase
            end
        end
    end

`ifdef CCI_RD_ARB_PERF_EN
    // Free-running grant and stall counters, one 32-bit slice per requester.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                perf_issue_cnt[i*32 +: 32] <= 32'd0;
                perf_stall_cnt[i*32 +: 32] <= 32'd0;
            end else begin
                perf_issue_cnt[i*32 +: 32] <= perf_issue_cnt[i*32 +: 32] + {31'd0, grant[i]};
                perf_stall_cnt[i*32 +: 32] <= perf_stall_cnt[i*32 +: 32] + {31'd0, req_valid[i] && !grant[i]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Directed bench for ccip_c0_rd_arbiter (NUM_REQ=2, MAX_OUT=4); optional perf checks under CCI_RD_ARB_PERF_EN.
module tb_ccip_c0_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 42;
    localparam int TAG_W   = 12;
    localparam int MAX_OUT = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic                      tx_c0_valid;
    logic [ADDR_W-1:0]         tx_c0_addr;
    logic [15:0]               tx_c0_mdata;
    logic                      tx_c0_almostfull;
    logic                      rx_c0_rdvalid;
    logic [15:0]               rx_c0_mdata;
    logic [511:0]              rx_c0_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [TAG_W-1:0]          rsp_tag;
    logic [511:0]              rsp_data;
    logic                      err_bad_id;
`ifdef CCI_RD_ARB_PERF_EN
    logic [NUM_REQ*32-1:0]     perf_issue_cnt;
    logic [NUM_REQ*32-1:0]     perf_stall_cnt;
    logic [31:0]               snap0;
    logic [31:0]               snap1;
`endif

    int errors = 0;
    int checks = 0;
    int issues;
    int grants;

    ccip_c0_rd_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .TAG_W   (TAG_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk_400_clk          (clk),
        .global_reset_reset_n (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_addr             (req_addr),
        .req_tag              (req_tag),
        .tx_c0_valid          (tx_c0_valid),
        .tx_c0_addr           (tx_c0_addr),
        .tx_c0_mdata          (tx_c0_mdata),
        .tx_c0_almostfull     (tx_c0_almostfull),
        .rx_c0_rdvalid        (rx_c0_rdvalid),
        .rx_c0_mdata          (rx_c0_mdata),
        .rx_c0_data           (rx_c0_data),
        .rsp_valid            (rsp_valid),
        .rsp_tag              (rsp_tag),
        .rsp_data             (rsp_data),
        .err_bad_id           (err_bad_id)
`ifdef CCI_RD_ARB_PERF_EN
        ,
        .perf_issue_cnt       (perf_issue_cnt),
        .perf_stall_cnt       (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        req_valid        = 2'b11;
        req_addr         = '0;
        req_tag          = '0;
        tx_c0_almostfull = 1'b0;
        rx_c0_rdvalid    = 1'b0;
        rx_c0_mdata      = 16'h0000;
        rx_c0_data       = '0;
        req_addr[0 +: ADDR_W]      = 42'h100;
        req_addr[ADDR_W +: ADDR_W] = 42'h200;
        req_tag[0 +: TAG_W]        = 12'h005;
        req_tag[TAG_W +: TAG_W]    = 12'h007;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_tx_valid", 64'(tx_c0_valid), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_err", 64'(err_bad_id), 64'h0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        tick();

        // Single request from requester 0 and its response
        req_valid = 2'b01;
        #1;
        chk("s1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        chk("s1_tx_valid", 64'(tx_c0_valid), 64'h1);
        chk("s1_tx_addr", 64'(tx_c0_addr), 64'h100);
        chk("s1_tx_mdata", 64'(tx_c0_mdata), 64'h0005);
        tick();
        chk("s1_tx_idle", 64'(tx_c0_valid), 64'h0);
        rx_c0_rdvalid = 1'b1;
        rx_c0_mdata   = 16'h0005;
        rx_c0_data    = {8{64'hDEAD_BEEF_0000_0005}};
        tick();
        rx_c0_rdvalid = 1'b0;
        chk("s1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("s1_rsp_tag", 64'(rsp_tag), 64'h5);
        chk("s1_rsp_data", rsp_data[63:0], 64'hDEAD_BEEF_0000_0005);
        chk("s1_err", 64'(err_bad_id), 64'h0);
        tick();
        chk("s1_rsp_clear", 64'(rsp_valid), 64'h0);

        // Both requesters continuously valid, responses looped back
        issues    = 0;
        req_valid = 2'b11;
        for (int n = 0; n < 100; n++) begin
            rx_c0_rdvalid = tx_c0_valid;
            rx_c0_mdata   = tx_c0_mdata;
            issues        = issues + int'(tx_c0_valid);
            #1;
            chk("s2_grant", 64'(req_ready), (n % 2 == 0) ? 64'h2 : 64'h1);
            tick();
        end
        req_valid     = 2'b00;
        rx_c0_rdvalid = tx_c0_valid;
        rx_c0_mdata   = tx_c0_mdata;
        issues        = issues + int'(tx_c0_valid);
        tick();
        rx_c0_rdvalid = 1'b0;
        chk("s2_issues", 64'(issues), 64'd100);
        chk("s2_err", 64'(err_bad_id), 64'h0);
        tick();

        // almostfull blocks new accepts; one registered request drains
        req_valid = 2'b11;
        #1;
        chk("s3_pre_grant", 64'(req_ready), 64'h2);
        tick();
        tx_c0_almostfull = 1'b1;
`ifdef CCI_RD_ARB_PERF_EN
        snap0 = perf_stall_cnt[31:0];
        snap1 = perf_stall_cnt[63:32];
`endif
        issues = 0;
        for (int k = 0; k < 10; k++) begin
            issues = issues + int'(tx_c0_valid);
            #1;
            chk("s3_blocked", 64'(req_ready), 64'h0);
            tick();
        end
        chk("s3_drain", 64'(issues), 64'd1);
`ifdef CCI_RD_ARB_PERF_EN
        chk("s3_stall0", 64'(perf_stall_cnt[31:0] - snap0), 64'd10);
        chk("s3_stall1", 64'(perf_stall_cnt[63:32] - snap1), 64'd10);
`endif
        tx_c0_almostfull = 1'b0;
        #1;
        chk("s3_resume", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;

        // Credit limit on requester 1
        req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("s4_ready", 64'(req_ready), 64'h2);
            tick();
        end
        chk("s4_tx_mdata", 64'(tx_c0_mdata), 64'h1007);
        chk("s4_tx_addr", 64'(tx_c0_addr), 64'h200);
        #1;
        chk("s4_full", 64'(req_ready), 64'h0);
        tick();
        chk("s4_full_hold", 64'(req_ready), 64'h0);
        rx_c0_rdvalid = 1'b1;
        rx_c0_mdata   = 16'h1007;
        #1;
        chk("s4_same_cycle", 64'(req_ready), 64'h0);
        tick();
        rx_c0_rdvalid = 1'b0;
        chk("s4_regain", 64'(req_ready), 64'h2);
        chk("s4_rsp_valid", 64'(rsp_valid), 64'h2);
        req_valid = 2'b00;
        tick();

        // Unknown ID, then grant+response on ID 0 in the same cycle
        rx_c0_rdvalid = 1'b1;
        rx_c0_mdata   = 16'hF001;
        tick();
        rx_c0_rdvalid = 1'b0;
        chk("s5_no_rsp", 64'(rsp_valid), 64'h0);
        chk("s5_err", 64'(err_bad_id), 64'h1);
        tick();
        chk("s5_sticky", 64'(err_bad_id), 64'h1);
        req_tag[0 +: TAG_W] = 12'h009;
        req_valid = 2'b01;
        tick();
        rx_c0_rdvalid = 1'b1;
        rx_c0_mdata   = 16'h0009;
        tick();
        rx_c0_rdvalid = 1'b0;
        chk("s5_rsp0", 64'(rsp_valid), 64'h1);
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            grants = grants + int'(req_ready == 2'b01);
            tick();
        end
        chk("s5_cnt_unchanged", 64'(grants), 64'd3);
        req_valid = 2'b00;

        // Reset with outstanding reads discards all state
        req_valid = 2'b10;
        rst_n     = 1'b0;
        #1;
        chk("s6_rst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("s6_tx_valid", 64'(tx_c0_valid), 64'h0);
        chk("s6_tx_mdata", 64'(tx_c0_mdata), 64'h0);
        chk("s6_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("s6_err", 64'(err_bad_id), 64'h0);
`ifdef CCI_RD_ARB_PERF_EN
        chk("s6_perf_issue", 64'(perf_issue_cnt), 64'h0);
        chk("s6_perf_stall", 64'(perf_stall_cnt), 64'h0);
`endif
        rst_n     = 1'b1;
        req_valid = 2'b01;
        grants    = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            grants = grants + int'(req_ready == 2'b01);
            tick();
        end
        chk("s6_cnt0_cleared", 64'(grants), 64'd4);
        req_valid = 2'b10;
        grants    = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            grants = grants + int'(req_ready == 2'b10);
            tick();
        end
        chk("s6_cnt1_cleared", 64'(grants), 64'd4);
        req_valid = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
